leng_find: RTL and testbench
============================

Name: leng_find

Overview:
- Registered decimal-digit counter: reports how many base-10 digits are needed to print a 32-bit unsigned value.
- Used ahead of number-to-ASCII or display formatting logic to size the output field.
- One result per enabled clock; result is held between enables.

Parameters:
- none. Input width is fixed at 32 bits and output width at 4 bits; maximum result is 10.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising clk.
- en  input  1  sample enable; when high, `in` is evaluated this cycle.
- in  input  32  unsigned binary value to measure.
- len  output  4  decimal digit count of the last enabled sample, registered.
- len_vld  output  1  high for exactly the cycle after each enabled sample, registered.

Behaviour:
- Reset:
  - On a rising clk with rst==0, set len<=4'd0 and len_vld<=0.
  - Reset has priority over en.
  - Reset in the middle of a stream discards any pending result; the next cycle shows len=0 and len_vld=0.
- Enabled sample:
  - On a rising clk with rst==1 and en==1, set len<=digits(in) and len_vld<=1.
  - Latency is 1 clock: the result is visible the cycle after en is sampled.
  - Back-to-back enables give one new result every cycle.
- Idle:
  - On a rising clk with rst==1 and en==0, len holds its previous value and len_vld<=0.
- digits(in), as a purely combinational decode of `in`:
  - in<10 gives 1; this includes in==0, which counts as one digit.
  - in<100 gives 2.
  - in<1000 gives 3.
  - in<10^4 gives 4.
  - in<10^5 gives 5.
  - in<10^6 gives 6.
  - in<10^7 gives 7.
  - in<10^8 gives 8.
  - in<10^9 gives 9.
  - Otherwise, up to 4294967295, gives 10.
- Thresholds:
  - Implement as 9 parallel unsigned 32-bit compares against the constants 10, 100, ..., 1000000000.
  - The result is 1 plus the count of thresholds that in is greater than or equal to.
  - Equivalently, use a priority encode of the compare results.
- Constraints:
  - Comparisons are unsigned; no sign interpretation of bit 31.
  - Output never exceeds 10; codes 11–15 are never produced.
  - No X propagation: a defined `in` always yields a defined len.
  - The design must close timing with the compare-and-encode in a single cycle; no multi-cycle or division-based approach.

Test Plan:
- Reset: hold rst=0 for 2 clocks with en=1 and in=1234 -> len=0 and len_vld=0 throughout; release rst=1 -> first result appears the cycle after the first sampled en.
- Sequence: en=1 each cycle with in=1010, 1, 12, 1234, 12345, 123456, 1234567 -> len = 4, 1, 2, 4, 5, 6, 7, each one cycle later, with len_vld=1 on every cycle.
- Boundaries:
  - in=0 -> 1; 9 -> 1; 10 -> 2; 99 -> 2; 100 -> 3.
  - in=999999999 -> 9; 1000000000 -> 10.
  - in=4294967295 -> 10; in=32'h80000000 (2147483648) -> 10, confirming the compare is unsigned.
- Hold: after in=12345 with en=1 (len=5), drop en=0 and change in to 7 for 3 cycles -> len stays 5 and len_vld=0; raise en again -> len=1.
- Mid-stream reset: stream results, then assert rst=0 for 1 cycle -> the next cycle shows len=0 and len_vld=0; deassert with en=1 and in=42 -> len=2 one cycle later.
- Random: 1000 random 32-bit values with random en -> len matches a reference model (string length of the decimal value) with 1-cycle latency, and len_vld equals en delayed by one cycle.

Source files
------------

// File: rtl/leng_find_if.sv
// leng_find_if
//   Bundles the sample-side and result-side signals of leng_find.
//   Signals:
//      en       sample enable, driven by the producer
//      in       32-bit unsigned value to measure, driven by the producer
//      len      registered decimal digit count (1..10, 0 after reset)
//      len_vld  high for the single cycle following each enabled sample
//   Modports:
//      master   producer/consumer side (drives en/in, observes len/len_vld)
//      slave    leng_find side (observes en/in, drives len/len_vld)
interface leng_find_if;
   logic        en;
   logic [31:0] in;
   logic [3:0]  len;
   logic        len_vld;

   modport master (
      output en,
      output in,
      input  len,
      input  len_vld
   );

   modport slave (
      input  en,
      input  in,
      output len,
      output len_vld
   );
endinterface

// File: rtl/leng_find.sv
// leng_find
//   Registered decimal-digit counter. Reports how many base-10 digits are
//   needed to print the 32-bit unsigned sample presented with en, one
//   cycle after it is sampled. The result is held while en is low.
//   Ports:
//      clk_i   system clock, rising edge
//      rst_ni  synchronous active-low reset, priority over en
//      bus     leng_find_if.slave: en, in (inputs); len, len_vld (outputs)
module leng_find (
   input  logic        clk_i,
   input  logic        rst_ni,
   leng_find_if.slave  bus
);

   localparam logic [31:0] THR [9] = '{
      32'd10,
      32'd100,
      32'd1000,
      32'd10000,
      32'd100000,
      32'd1000000,
      32'd10000000,
      32'd100000000,
      32'd1000000000
   };

   logic [8:0] ge;
   logic [3:0] digits;
   logic [3:0] len_q,     len_d;
   logic       len_vld_q, len_vld_d;

   // Nine independent unsigned compares; operands are declared unsigned so
   // bit 31 carries magnitude only.
   always_comb begin
      for (int i = 0; i < 9; i++) begin
         ge[i] = (bus.in >= THR[i]);
      end
   end

   // The compare vector is thermometer coded, so the highest set bit fixes
   // the digit count. A priority encode keeps the result bounded to 1..10.
   always_comb begin
      digits = 4'd1;
      for (int i = 0; i < 9; i++) begin
         if (ge[i]) digits = 4'(i + 2);
      end
   end

   always_comb begin
      len_d     = len_q;
      len_vld_d = 1'b0;
      if (bus.en) begin
         len_d     = digits;
         len_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         len_q     <= 4'd0;
         len_vld_q <= 1'b0;
      end else begin
         len_q     <= len_d;
         len_vld_q <= len_vld_d;
      end
   end

   assign bus.len     = len_q;
   assign bus.len_vld = len_vld_q;

endmodule

// File: tb/tb_leng_find.sv
// tb_leng_find
//   Directed and random checks for leng_find: reset, digit-count sequence,
//   decade boundaries, unsigned top-bit handling, hold, mid-stream reset,
//   and a randomized run against a repeated-division reference.
module tb_leng_find;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   leng_find_if bus ();

   leng_find dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] ref_digits(input logic [31:0] v);
      logic [31:0] t;
      int          n;
      t = v;
      n = 1;
      while (t >= 32'd10) begin
         t = t / 32'd10;
         n++;
      end
      return 4'(n);
   endfunction

   task automatic drive(input logic r, input logic e, input logic [31:0] v);
      rst_n  = r;
      bus.en = e;
      bus.in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] exp_len, input logic exp_vld);
      n_assert++;
      assert (bus.len === exp_len)
      else begin
         n_fail++;
         $error("FAIL %s len: observed %0d expected %0d", tag, bus.len, exp_len);
      end
      n_assert++;
      assert (bus.len_vld === exp_vld)
      else begin
         n_fail++;
         $error("FAIL %s len_vld: observed %0b expected %0b", tag, bus.len_vld, exp_vld);
      end
   endtask

   logic [31:0] rv;
   logic        re;
   logic [3:0]  exp_hold;

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.en   = 1'b1;
      bus.in   = 32'd1234;
      #2;

      // Reset held two clocks with en high
      drive(1'b0, 1'b1, 32'd1234);  check("reset_c0", 4'd0, 1'b0);
      drive(1'b0, 1'b1, 32'd1234);  check("reset_c1", 4'd0, 1'b0);

      // Sequence
      drive(1'b1, 1'b1, 32'd1010);    check("seq_1010", 4'd4, 1'b1);
      drive(1'b1, 1'b1, 32'd1);       check("seq_1", 4'd1, 1'b1);
      drive(1'b1, 1'b1, 32'd12);      check("seq_12", 4'd2, 1'b1);
      drive(1'b1, 1'b1, 32'd1234);    check("seq_1234", 4'd4, 1'b1);
      drive(1'b1, 1'b1, 32'd12345);   check("seq_12345", 4'd5, 1'b1);
      drive(1'b1, 1'b1, 32'd123456);  check("seq_123456", 4'd6, 1'b1);
      drive(1'b1, 1'b1, 32'd1234567); check("seq_1234567", 4'd7, 1'b1);

      // Boundaries
      drive(1'b1, 1'b1, 32'd0);          check("bnd_0", 4'd1, 1'b1);
      drive(1'b1, 1'b1, 32'd9);          check("bnd_9", 4'd1, 1'b1);
      drive(1'b1, 1'b1, 32'd10);         check("bnd_10", 4'd2, 1'b1);
      drive(1'b1, 1'b1, 32'd99);         check("bnd_99", 4'd2, 1'b1);
      drive(1'b1, 1'b1, 32'd100);        check("bnd_100", 4'd3, 1'b1);
      drive(1'b1, 1'b1, 32'd9999999);    check("bnd_9999999", 4'd7, 1'b1);
      drive(1'b1, 1'b1, 32'd10000000);   check("bnd_10000000", 4'd8, 1'b1);
      drive(1'b1, 1'b1, 32'd99999999);   check("bnd_99999999", 4'd8, 1'b1);
      drive(1'b1, 1'b1, 32'd100000000);  check("bnd_100000000", 4'd9, 1'b1);
      drive(1'b1, 1'b1, 32'd999999999);  check("bnd_999999999", 4'd9, 1'b1);
      drive(1'b1, 1'b1, 32'd1000000000); check("bnd_1e9", 4'd10, 1'b1);
      drive(1'b1, 1'b1, 32'hFFFFFFFF);   check("bnd_max", 4'd10, 1'b1);
      drive(1'b1, 1'b1, 32'h80000000);   check("bnd_msb", 4'd10, 1'b1);
      drive(1'b1, 1'b1, 32'd9999);       check("bnd_9999", 4'd4, 1'b1);
      drive(1'b1, 1'b1, 32'd99999);      check("bnd_99999", 4'd5, 1'b1);
      drive(1'b1, 1'b1, 32'd999999);     check("bnd_999999", 4'd6, 1'b1);

      // Hold
      drive(1'b1, 1'b1, 32'd12345); check("hold_load", 4'd5, 1'b1);
      drive(1'b1, 1'b0, 32'd7);     check("hold_c0", 4'd5, 1'b0);
      drive(1'b1, 1'b0, 32'd7);     check("hold_c1", 4'd5, 1'b0);
      drive(1'b1, 1'b0, 32'd7);     check("hold_c2", 4'd5, 1'b0);
      drive(1'b1, 1'b1, 32'd7);     check("hold_resume", 4'd1, 1'b1);

      // Mid-stream reset
      drive(1'b1, 1'b1, 32'd100);   check("mid_pre0", 4'd3, 1'b1);
      drive(1'b1, 1'b1, 32'd54321); check("mid_pre1", 4'd5, 1'b1);
      drive(1'b0, 1'b1, 32'd777);   check("mid_rst", 4'd0, 1'b0);
      drive(1'b1, 1'b1, 32'd42);    check("mid_after", 4'd2, 1'b1);

      // Random: shift spreads values across all digit counts
      exp_hold = 4'd2;
      for (int i = 0; i < 1000; i++) begin
         re = 1'($urandom_range(0, 1));
         rv = $urandom >> $urandom_range(0, 31);
         drive(1'b1, re, rv);
         if (re) exp_hold = ref_digits(rv);
         check("random", exp_hold, re);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
